// File: rtl/aes_pkg.sv
// Shared AES T-box constants, word type and the round-robin pointer helper.
package aes_pkg;

    localparam int TBOX_AW = 8;
    localparam int TBOX_DW = 24;

    typedef logic [TBOX_DW-1:0] tbox_word_t;

    // Next round-robin position after ptr, wrapping from n-1 back to 0.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/aes_tbox_r.sv
// Combinational decryption T-box: d = {3*s, 2*s, s} with s = InvSbox(a) in GF(2^8).
module aes_tbox_r import aes_pkg::*; (
    input  logic [TBOX_AW-1:0] a,
    output tbox_word_t         d
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] s;

    assign s = gf_inv(inv_affine(a));
    assign d = {gf_mul(s, 8'h03), gf_mul(s, 8'h02), s};

endmodule

// File: rtl/aes_tbox_arb.sv
// Round-robin arbiter sharing one aes_tbox_r across NREQ requesters, two-cycle response.
// Define AES_TBOX_ARB_PRIO_EN to give requester 0 fixed priority over the round-robin.
module aes_tbox_arb import aes_pkg::*; #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [8*NREQ-1:0]  req_addr,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [TBOX_DW-1:0] rsp_data,
    output logic [IDW-1:0]     rsp_id,
    output logic               busy
);

    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic               s1_valid_q, s2_valid_q;
    logic [TBOX_AW-1:0] s1_addr_q;
    logic [IDW-1:0]     s1_id_q, s2_id_q;
    tbox_word_t         s2_data_q;
    tbox_word_t         tbox_d;

    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [TBOX_AW-1:0] grant_addr;
    logic               hs;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int k);
        int sum;
        sum = int'(p) + k;
        if (sum >= NREQ) sum = sum - NREQ;
        return IDW'(sum);
    endfunction

    // First requester at or above rr_ptr, with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[wrap_idx(rr_ptr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(rr_ptr_q, k);
            end
        end
`ifdef AES_TBOX_ARB_PRIO_EN
        if (req_valid[0]) begin
            grant_found = 1'b1;
            grant_idx   = '0;
        end
`endif
    end

    always_comb begin
        grant_addr = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == IDW'(k)) grant_addr = req_addr[k*8 +: 8];
        end
    end

    assign hs        = grant_found & ~flush;
    assign req_ready = hs ? (NREQ'(1) << grant_idx) : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
`ifdef AES_TBOX_ARB_PRIO_EN
        if (hs && !req_valid[0]) rr_ptr_d = IDW'(rr_next(int'(grant_idx), NREQ));
`else
        if (hs) rr_ptr_d = IDW'(rr_next(int'(grant_idx), NREQ));
`endif
    end

    aes_tbox_r u_tbox (
        .a (s1_addr_q),
        .d (tbox_d)
    );

    // Payload registers only load with a live entry so rsp_data/rsp_id hold between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_data_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= hs;
            if (hs) begin
                s1_addr_q <= grant_addr;
                s1_id_q   <= grant_idx;
            end
            s2_valid_q <= s1_valid_q & ~flush;
            if (s1_valid_q && !flush) begin
                s2_id_q   <= s1_id_q;
                s2_data_q <= tbox_d;
            end
        end
    end

    assign rsp_valid = s2_valid_q ? (NREQ'(1) << s2_id_q) : '0;
    assign rsp_data  = s2_data_q;
    assign rsp_id    = s2_id_q;
    assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_aes_tbox_arb.sv
// Bench for aes_tbox_arb: directed vector table, random traffic against a reference model, async reset.
module tb_aes_tbox_arb;

    localparam int NREQ = 4;
    localparam int W    = 1 + 2 + 24;
    localparam logic [31:0] ABCD = 32'hFF_00_63_01;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [3:0]  req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [23:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;

    aes_tbox_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // ---------------- reference model ----------------
    logic [7:0] inv_sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] x;
        logic [7:0] inv;
        logic [7:0] s;
        for (int i = 0; i < 256; i++) begin
            x   = 8'(i);
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gm(x, 8'(b)) == 8'h01) inv = 8'(b);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            inv_sbox[s] = x;
        end
    endtask

    function automatic logic [23:0] tbox_model(input logic [7:0] a);
        logic [7:0] s;
        s = inv_sbox[a];
        return {gm(s, 8'h03), gm(s, 8'h02), s};
    endfunction

    int            m_ptr;
    logic [W-1:0]  exp_q[$];
    logic [1:0]    last_id;
    logic [23:0]   last_data;

    task automatic model_init();
        m_ptr = 0;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
        last_id   = 2'd0;
        last_data = 24'd0;
    endtask

    // Winner is the requester closest to the pointer going upward.
    function automatic int model_grant(input logic [3:0] v, input int ptr);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = NREQ;
`ifdef AES_TBOX_ARB_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            d = (i - ptr + NREQ) % NREQ;
            if (v[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    logic [3:0]  s_ready, s_rv;
    logic [1:0]  s_id;
    logic [23:0] s_data;
    logic        s_busy;

    task automatic cycle(input logic [3:0] v, input logic [31:0] a, input logic f);
        int           g;
        logic [W-1:0] e1, e2, tmp;
        logic [3:0]   exp_ready, exp_rv;
        logic [7:0]   ga;
        req_valid = v;
        req_addr  = a;
        flush     = f;
        @(negedge clk);
        s_ready = req_ready;
        s_rv    = rsp_valid;
        s_id    = rsp_id;
        s_data  = rsp_data;
        s_busy  = busy;
        g = model_grant(v, m_ptr);
        exp_ready = (g >= 0 && !f) ? (4'b0001 << g) : 4'b0000;
        e1 = exp_q[exp_q.size()-1];
        e2 = exp_q[exp_q.size()-2];
        if (e2[W-1]) begin
            last_id   = e2[25:24];
            last_data = e2[23:0];
        end
        exp_rv = e2[W-1] ? (4'b0001 << e2[25:24]) : 4'b0000;
        check("m_req_ready", 32'(s_ready), 32'(exp_ready));
        check("m_rsp_valid", 32'(s_rv), 32'(exp_rv));
        check("m_rsp_id", 32'(s_id), 32'(last_id));
        check("m_rsp_data", 32'(s_data), 32'(last_data));
        check("m_busy", 32'(s_busy), 32'(e1[W-1] | e2[W-1]));
        if (f) begin
            tmp = exp_q.pop_back();
            tmp[W-1] = 1'b0;
            exp_q.push_back(tmp);
        end
        if (g >= 0 && !f) begin
            ga = a[8*g +: 8];
            exp_q.push_back({1'b1, 2'(g), tbox_model(ga)});
`ifdef AES_TBOX_ARB_PRIO_EN
            if (!v[0]) m_ptr = (g + 1) % NREQ;
`else
            m_ptr = (g + 1) % NREQ;
`endif
        end else begin
            exp_q.push_back('0);
        end
        if (exp_q.size() > 4) void'(exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0]  v;
        logic        f;
        logic [3:0]  ready;
        logic [3:0]  rv;
        logic [1:0]  id;
        logic [23:0] data;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] v, input logic f, input logic [3:0] ready,
                       input logic [3:0] rv, input logic [1:0] id, input logic [23:0] data,
                       input logic b);
        vec_t e;
        e.v = v; e.f = f; e.ready = ready; e.rv = rv; e.id = id; e.data = data; e.busy = b;
        tbl.push_back(e);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 4'b0000;
        req_addr  = 32'd0;
        build_sbox();

        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        model_init();

`ifdef AES_TBOX_ARB_PRIO_EN
        add(4'b0011, 0, 4'b0001, 4'b0000, 0, 24'h000000, 0);
        add(4'b0011, 0, 4'b0001, 4'b0000, 0, 24'h000000, 1);
        add(4'b0011, 0, 4'b0001, 4'b0001, 0, 24'h1B1209, 1);
        add(4'b0010, 0, 4'b0010, 4'b0001, 0, 24'h1B1209, 1);
        add(4'b0000, 0, 4'b0000, 4'b0001, 0, 24'h1B1209, 1);
        add(4'b0000, 0, 4'b0000, 4'b0010, 1, 24'h000000, 1);
        add(4'b0000, 0, 4'b0000, 4'b0000, 1, 24'h000000, 0);
`else
        add(4'b0000, 0, 4'b0000, 4'b0000, 0, 24'h000000, 0);
        add(4'b0100, 0, 4'b0100, 4'b0000, 0, 24'h000000, 0);
        add(4'b0000, 0, 4'b0000, 4'b0000, 0, 24'h000000, 1);
        add(4'b0000, 0, 4'b0000, 4'b0100, 2, 24'hF6A452, 1);
        add(4'b1000, 0, 4'b1000, 4'b0000, 2, 24'hF6A452, 0);
        add(4'b1111, 0, 4'b0001, 4'b0000, 2, 24'hF6A452, 1);
        add(4'b1111, 0, 4'b0010, 4'b1000, 3, 24'h87FA7D, 1);
        add(4'b1111, 0, 4'b0100, 4'b0001, 0, 24'h1B1209, 1);
        add(4'b1111, 0, 4'b1000, 4'b0010, 1, 24'h000000, 1);
        add(4'b1111, 0, 4'b0001, 4'b0100, 2, 24'hF6A452, 1);
        add(4'b1111, 0, 4'b0010, 4'b1000, 3, 24'h87FA7D, 1);
        add(4'b0000, 0, 4'b0000, 4'b0001, 0, 24'h1B1209, 1);
        add(4'b0000, 0, 4'b0000, 4'b0010, 1, 24'h000000, 1);
        // pointer at 2 with requesters 1 and 3: 3 wins, then 1
        add(4'b1010, 0, 4'b1000, 4'b0000, 1, 24'h000000, 0);
        add(4'b1010, 0, 4'b0010, 4'b0000, 1, 24'h000000, 1);
        add(4'b0000, 0, 4'b0000, 4'b1000, 3, 24'h87FA7D, 1);
        add(4'b0000, 0, 4'b0000, 4'b0010, 1, 24'h000000, 1);
        // requester 3 withdraws before its turn and never gets a response
        add(4'b1100, 0, 4'b0100, 4'b0000, 1, 24'h000000, 0);
        add(4'b0000, 0, 4'b0000, 4'b0000, 1, 24'h000000, 1);
        add(4'b0000, 0, 4'b0000, 4'b0100, 2, 24'hF6A452, 1);
        add(4'b0000, 0, 4'b0000, 4'b0000, 2, 24'hF6A452, 0);
        // two grants, then flush: the second response is dropped, pointer kept
        add(4'b1001, 0, 4'b1000, 4'b0000, 2, 24'hF6A452, 0);
        add(4'b1001, 0, 4'b0001, 4'b0000, 2, 24'hF6A452, 1);
        add(4'b1001, 1, 4'b0000, 4'b1000, 3, 24'h87FA7D, 1);
        add(4'b0000, 0, 4'b0000, 4'b0000, 3, 24'h87FA7D, 0);
        add(4'b0000, 0, 4'b0000, 4'b0000, 3, 24'h87FA7D, 0);
        add(4'b1001, 0, 4'b1000, 4'b0000, 3, 24'h87FA7D, 0);
        add(4'b0000, 0, 4'b0000, 4'b0000, 3, 24'h87FA7D, 1);
        add(4'b0000, 0, 4'b0000, 4'b1000, 3, 24'h87FA7D, 1);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].v, ABCD, tbl[i].f);
            check($sformatf("v%0d_req_ready", i), 32'(s_ready), 32'(tbl[i].ready));
            check($sformatf("v%0d_rsp_valid", i), 32'(s_rv), 32'(tbl[i].rv));
            check($sformatf("v%0d_rsp_id", i), 32'(s_id), 32'(tbl[i].id));
            check($sformatf("v%0d_rsp_data", i), 32'(s_data), 32'(tbl[i].data));
            check($sformatf("v%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
        end

        // random traffic, including withdrawals and occasional flushes
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 15) == 0));
        end

        // asynchronous reset with responses in flight
        cycle(4'b1111, ABCD, 1'b0);
        cycle(4'b1111, ABCD, 1'b0);
        req_valid = 4'b0000;
        flush     = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_init();
        for (int i = 0; i < 4; i++) cycle(4'b0000, 32'd0, 1'b0);
        cycle(4'b0100, ABCD, 1'b0);
        for (int i = 0; i < 3; i++) cycle(4'b0000, 32'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
